// File: rtl/rvga_types.sv
// Shared types for the fetch front-end: word type, fetch FSM states and
// the (pc, ir) entry handed to decode.
package rvga_types;

    typedef logic [31:0] rvga_word;

    typedef enum logic [1:0] {
        e_FETCH_BOOT,
        e_FETCH_RUN,
        e_FETCH_FLUSH
    } rvga_fetch_state;

    typedef struct packed {
        rvga_word pc;
        rvga_word ir;
    } rvga_fetch_entry;

    localparam int RVGA_INST_BYTES = 4;

endpackage

// File: rtl/rvga_fifo.sv
// Small synchronous FIFO with clear; head is read straight from storage.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module rvga_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_reg == '0);
    assign full_o  = (count_reg == CNT_W'(DEPTH));
    assign count_o = count_reg;
    assign head_o  = mem_reg[rd_ptr_reg];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) begin
            mem_reg[wr_ptr_reg] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, issues in-order imem requests, buffers
// responses for decode and squashes wrong-path words on redirect.
// Define RVGA_FETCH_PERF_EN to add drop/stall performance counters.
module inst_fetch
    import rvga_types::*;
#(
    parameter rvga_word RESET_PC  = 32'h0000_0000,
    parameter int       BUF_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        imem_req_v_o,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_req_ready_i,
    input  logic        imem_resp_v_i,
    input  logic [31:0] imem_resp_data_i,
    input  logic        redirect_v_i,
    input  logic [31:0] redirect_pc_i,
    output logic        fetch_v_o,
    output logic [31:0] fetch_pc_o,
    output logic [31:0] fetch_ir_o,
    input  logic        fetch_ready_i
`ifdef RVGA_FETCH_PERF_EN
    ,
    output logic [31:0] perf_drop_cnt_o,
    output logic [31:0] perf_stall_cnt_o
`endif
);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    rvga_fetch_state state_reg;
    rvga_word        pc_reg;
    logic [CNT_W-1:0] out_cnt_reg;
    logic [CNT_W-1:0] out_cnt_next;
    logic [CNT_W:0]   occupancy;

    logic            req_fire;
    rvga_word        ifq_head;
    logic            ifq_full;
    logic            ifq_empty;
    logic [CNT_W-1:0] ifq_count;

    logic            buf_push;
    logic            buf_pop;
    logic            buf_full;
    logic            buf_empty;
    logic [CNT_W-1:0] buf_count;
    rvga_fetch_entry buf_head;
    rvga_fetch_entry buf_push_data;

    // In-flight plus buffered words never exceed the buffer size, so a
    // response always has a slot waiting for it.
    assign occupancy       = {1'b0, out_cnt_reg} + {1'b0, buf_count};
    assign imem_req_v_o    = (state_reg == e_FETCH_RUN) && (occupancy < (CNT_W + 1)'(BUF_DEPTH));
    assign imem_req_addr_o = imem_req_v_o ? pc_reg : '0;
    assign req_fire        = imem_req_v_o && imem_req_ready_i;
    assign out_cnt_next    = out_cnt_reg + CNT_W'(req_fire) - CNT_W'(imem_resp_v_i);

    assign buf_push      = imem_resp_v_i && (state_reg == e_FETCH_RUN) && !redirect_v_i;
    assign buf_pop       = fetch_v_o && fetch_ready_i;
    assign buf_push_data = '{pc: ifq_head, ir: imem_resp_data_i};

    assign fetch_v_o  = !buf_empty;
    assign fetch_pc_o = buf_empty ? '0 : buf_head.pc;
    assign fetch_ir_o = buf_empty ? '0 : buf_head.ir;

    // PCs of issued requests; every response pops one, kept or dropped.
    rvga_fifo #(
        .WIDTH (32),
        .DEPTH (BUF_DEPTH)
    ) u_inflight_q (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (req_fire),
        .push_data_i (pc_reg),
        .pop_i       (imem_resp_v_i),
        .clear_i     (1'b0),
        .head_o      (ifq_head),
        .full_o      (ifq_full),
        .empty_o     (ifq_empty),
        .count_o     (ifq_count)
    );

    rvga_fifo #(
        .WIDTH ($bits(rvga_fetch_entry)),
        .DEPTH (BUF_DEPTH)
    ) u_resp_buf (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (buf_push),
        .push_data_i (buf_push_data),
        .pop_i       (buf_pop),
        .clear_i     (redirect_v_i),
        .head_o      (buf_head),
        .full_o      (buf_full),
        .empty_o     (buf_empty),
        .count_o     (buf_count)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg   <= e_FETCH_BOOT;
            pc_reg      <= RESET_PC;
            out_cnt_reg <= '0;
        end else begin
            out_cnt_reg <= out_cnt_next;
            if (redirect_v_i) begin
                pc_reg <= {redirect_pc_i[31:2], 2'b00};
            end else if (req_fire) begin
                pc_reg <= pc_reg + rvga_word'(RVGA_INST_BYTES);
            end
            case (state_reg)
                e_FETCH_BOOT: state_reg <= e_FETCH_RUN;
                e_FETCH_RUN: begin
                    if (redirect_v_i && (out_cnt_next != '0)) begin
                        state_reg <= e_FETCH_FLUSH;
                    end
                end
                e_FETCH_FLUSH: begin
                    if (out_cnt_next == '0) begin
                        state_reg <= e_FETCH_RUN;
                    end
                end
                default: state_reg <= e_FETCH_BOOT;
            endcase
        end
    end

`ifdef RVGA_FETCH_PERF_EN
    logic drop_evt;
    logic stall_evt;

    assign drop_evt  = imem_resp_v_i && ((state_reg == e_FETCH_FLUSH) || redirect_v_i);
    assign stall_evt = fetch_v_o && !fetch_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perf_drop_cnt_o  <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (drop_evt && (perf_drop_cnt_o != '1)) begin
                perf_drop_cnt_o <= perf_drop_cnt_o + 32'd1;
            end
            if (stall_evt && (perf_stall_cnt_o != '1)) begin
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            end
        end
    end
`endif

    a_buf_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(buf_push && buf_full && !buf_pop));
    a_resp_has_request: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(imem_resp_v_i && ifq_empty));
    a_inflight_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(req_fire && ifq_full));
    a_outstanding_tracks_queue: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        ifq_count == out_cnt_reg);

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: per-cycle expectation tables plus an in-order
// scoreboard of fetched (pc, ir) pairs; a second instance covers PC wrap.
module tb_inst_fetch;

    typedef struct {
        logic        rdr_v;
        logic [31:0] rdr_pc;
        logic        f_rdy;
        logic        m_rdy;
        logic        e_req_v;
        logic [31:0] e_addr;
        logic        e_fv;
        logic [31:0] e_fpc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_txn_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } exp_t;

    localparam logic [31:0] PC2_OFS = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_v, req_v2;
    logic [31:0] req_addr, req_addr2;
    logic        req_rdy;
    logic        resp_v;
    logic [31:0] resp_data;
    logic        rdr_v;
    logic [31:0] rdr_pc;
    logic        f_v, f_v2;
    logic [31:0] f_pc, f_pc2, f_ir, f_ir2;
    logic        f_rdy;
`ifdef RVGA_FETCH_PERF_EN
    logic [31:0] drop_cnt, stall_cnt, drop_cnt2, stall_cnt2;
`endif

    int checks = 0;
    int failures = 0;
    vec_t     vecs[$];
    mem_txn_t mem_q[$];
    exp_t     exp_q[$];

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .imem_req_v_o     (req_v),
        .imem_req_addr_o  (req_addr),
        .imem_req_ready_i (req_rdy),
        .imem_resp_v_i    (resp_v),
        .imem_resp_data_i (resp_data),
        .redirect_v_i     (rdr_v),
        .redirect_pc_i    (rdr_pc),
        .fetch_v_o        (f_v),
        .fetch_pc_o       (f_pc),
        .fetch_ir_o       (f_ir),
        .fetch_ready_i    (f_rdy)
`ifdef RVGA_FETCH_PERF_EN
        ,
        .perf_drop_cnt_o  (drop_cnt),
        .perf_stall_cnt_o (stall_cnt)
`endif
    );

    inst_fetch #(.RESET_PC(PC2_OFS), .BUF_DEPTH(2)) dut_wrap (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .imem_req_v_o     (req_v2),
        .imem_req_addr_o  (req_addr2),
        .imem_req_ready_i (req_rdy),
        .imem_resp_v_i    (resp_v),
        .imem_resp_data_i (resp_data),
        .redirect_v_i     (rdr_v),
        .redirect_pc_i    (rdr_pc),
        .fetch_v_o        (f_v2),
        .fetch_pc_o       (f_pc2),
        .fetch_ir_o       (f_ir2),
        .fetch_ready_i    (f_rdy)
`ifdef RVGA_FETCH_PERF_EN
        ,
        .perf_drop_cnt_o  (drop_cnt2),
        .perf_stall_cnt_o (stall_cnt2)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rv, input logic [31:0] rpc, input logic fr, input logic mr,
                       input logic erv, input logic [31:0] ea, input logic efv,
                       input logic [31:0] epc);
        vec_t v;
        v.rdr_v = rv; v.rdr_pc = rpc; v.f_rdy = fr; v.m_rdy = mr;
        v.e_req_v = erv; v.e_addr = ea; v.e_fv = efv; v.e_fpc = epc;
        vecs.push_back(v);
    endtask

    task automatic chk_zero_outputs(input string scen);
        chk({scen, " rst req_v"}, {31'b0, req_v}, 32'h0);
        chk({scen, " rst req_addr"}, req_addr, 32'h0);
        chk({scen, " rst fetch_v"}, {31'b0, f_v}, 32'h0);
        chk({scen, " rst fetch_pc"}, f_pc, 32'h0);
        chk({scen, " rst fetch_ir"}, f_ir, 32'h0);
`ifdef RVGA_FETCH_PERF_EN
        chk({scen, " rst perf_drop"}, drop_cnt, 32'h0);
        chk({scen, " rst perf_stall"}, stall_cnt, 32'h0);
`endif
    endtask

    // Called at posedge+1; leaves the bench in the first post-reset (BOOT) cycle.
    task automatic do_reset(input string scen);
        rst_n = 1'b0;
        req_rdy = 1'b0; resp_v = 1'b0; resp_data = '0;
        rdr_v = 1'b0; rdr_pc = '0; f_rdy = 1'b0;
        mem_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs(scen);
        rst_n = 1'b1;
    endtask

    task automatic run_vecs(input string scen, input int lat, input bit chk2);
        vec_t     v;
        exp_t     e;
        mem_txn_t m;
        string    tag;
        for (int c = 0; c < vecs.size(); c++) begin
            v = vecs[c];
            tag = $sformatf("%s c%0d", scen, c);
            if (mem_q.size() > 0 && mem_q[0].due <= c) begin
                resp_v = 1'b1;
                resp_data = mem_word(mem_q[0].addr);
                void'(mem_q.pop_front());
            end else begin
                resp_v = 1'b0;
                resp_data = '0;
            end
            rdr_v = v.rdr_v; rdr_pc = v.rdr_pc; f_rdy = v.f_rdy; req_rdy = v.m_rdy;
            #1;
            chk({tag, " req_v"}, {31'b0, req_v}, {31'b0, v.e_req_v});
            chk({tag, " req_addr"}, req_addr, v.e_req_v ? v.e_addr : 32'h0);
            chk({tag, " fetch_v"}, {31'b0, f_v}, {31'b0, v.e_fv});
            chk({tag, " fetch_pc"}, f_pc, v.e_fv ? v.e_fpc : 32'h0);
            chk({tag, " fetch_ir"}, f_ir, v.e_fv ? mem_word(v.e_fpc) : 32'h0);
            if (chk2) begin
                chk({tag, " wrap req_addr"}, req_addr2, v.e_req_v ? v.e_addr + PC2_OFS : 32'h0);
                chk({tag, " wrap fetch_pc"}, f_pc2, v.e_fv ? v.e_fpc + PC2_OFS : 32'h0);
                chk({tag, " wrap fetch_ir"}, f_ir2, v.e_fv ? mem_word(v.e_fpc) : 32'h0);
            end
            if (v.e_fv && v.f_rdy) begin
                if (exp_q.size() == 0) begin
                    chk({tag, " sb_underflow"}, 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk({tag, " sb_pc"}, f_pc, e.pc);
                    chk({tag, " sb_ir"}, f_ir, e.ir);
                    $display("%s fetch pc=%h ir=%h exp_pc=%h", tag, f_pc, f_ir, e.pc);
                end
            end
            if (req_v && req_rdy) begin
                m.addr = req_addr;
                m.due  = c + lat;
                mem_q.push_back(m);
            end
            if (v.e_req_v && v.m_rdy) begin
                e.pc = v.e_addr;
                e.ir = mem_word(v.e_addr);
                exp_q.push_back(e);
            end
            if (v.rdr_v) begin
                exp_q.delete();
            end
            @(posedge clk);
            #1;
        end
        resp_v = 1'b0;
        rdr_v = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        // Steady streaming, 1-cycle memory; wrap instance runs alongside.
        do_reset("basic");
        vecs.delete();
        add(0, 0, 1, 1, 0, 32'h00, 0, 32'h00);
        add(0, 0, 1, 1, 1, 32'h00, 0, 32'h00);
        add(0, 0, 1, 1, 1, 32'h04, 0, 32'h00);
        add(0, 0, 1, 1, 0, 32'h00, 1, 32'h00);
        add(0, 0, 1, 1, 1, 32'h08, 1, 32'h04);
        add(0, 0, 1, 1, 1, 32'h0C, 0, 32'h00);
        add(0, 0, 1, 1, 0, 32'h00, 1, 32'h08);
        add(0, 0, 1, 1, 1, 32'h10, 1, 32'h0C);
        run_vecs("basic", 1, 1'b1);

        // Decode stalled for 5 visible cycles, then released.
        do_reset("stall");
        vecs.delete();
        add(0, 0, 0, 1, 0, 32'h00, 0, 32'h00);
        add(0, 0, 0, 1, 1, 32'h00, 0, 32'h00);
        add(0, 0, 0, 1, 1, 32'h04, 0, 32'h00);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 0, 32'h00, 1, 32'h00);
        add(0, 0, 1, 1, 0, 32'h00, 1, 32'h00);
        add(0, 0, 1, 1, 1, 32'h08, 1, 32'h04);
        add(0, 0, 1, 1, 1, 32'h0C, 0, 32'h00);
        add(0, 0, 1, 1, 0, 32'h00, 1, 32'h08);
        add(0, 0, 1, 1, 1, 32'h10, 1, 32'h0C);
        run_vecs("stall", 1, 1'b0);
`ifdef RVGA_FETCH_PERF_EN
        chk("stall perf_stall", stall_cnt, 32'd5);
        chk("stall perf_drop", drop_cnt, 32'd0);
`endif

        // Redirect to an unaligned target with two requests outstanding.
        do_reset("redirect");
        vecs.delete();
        add(0, 0, 1, 1, 0, 32'h000, 0, 32'h000);
        add(0, 0, 1, 1, 1, 32'h000, 0, 32'h000);
        add(0, 0, 1, 1, 1, 32'h004, 0, 32'h000);
        add(1, 32'h103, 1, 1, 0, 32'h000, 0, 32'h000);
        add(0, 0, 1, 1, 0, 32'h000, 0, 32'h000);
        add(0, 0, 1, 1, 0, 32'h000, 0, 32'h000);
        add(0, 0, 1, 1, 1, 32'h100, 0, 32'h000);
        add(0, 0, 1, 1, 1, 32'h104, 0, 32'h000);
        add(0, 0, 1, 1, 0, 32'h000, 0, 32'h000);
        add(0, 0, 1, 1, 0, 32'h000, 0, 32'h000);
        add(0, 0, 1, 1, 0, 32'h000, 1, 32'h100);
        add(0, 0, 1, 1, 1, 32'h108, 1, 32'h104);
        add(0, 0, 1, 1, 1, 32'h10C, 0, 32'h000);
        run_vecs("redirect", 3, 1'b0);
`ifdef RVGA_FETCH_PERF_EN
        chk("redirect perf_drop", drop_cnt, 32'd2);
        chk("redirect perf_stall", stall_cnt, 32'd0);
`endif
        // Asynchronous reset in mid-cycle with requests still in flight.
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("async");

        // Redirect coinciding with a response and a request handshake.
        do_reset("redir_same");
        vecs.delete();
        add(0, 0, 1, 1, 0, 32'h00, 0, 32'h00);
        add(0, 0, 1, 1, 1, 32'h00, 0, 32'h00);
        add(1, 32'h40, 1, 1, 1, 32'h04, 0, 32'h00);
        add(0, 0, 1, 1, 0, 32'h00, 0, 32'h00);
        add(0, 0, 1, 1, 1, 32'h40, 0, 32'h00);
        add(0, 0, 1, 1, 1, 32'h44, 0, 32'h00);
        add(0, 0, 1, 1, 0, 32'h00, 1, 32'h40);
        add(0, 0, 1, 1, 1, 32'h48, 1, 32'h44);
        run_vecs("redir_same", 1, 1'b0);
`ifdef RVGA_FETCH_PERF_EN
        chk("redir_same perf_drop", drop_cnt, 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Front-end stage directly upstream of the instruction decoder; produces the (pc, ir) pair it consumes.
- Owns the PC register, issues in-order requests to instruction memory over a valid/ready request channel and a valid-only response channel, and buffers returned words.
- Presents them to decode through a valid/ready interface.
- Accepts PC redirects from execute (branch/jump) and discards wrong-path words.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- BUF_DEPTH, 2, entries in the response buffer; also the maximum outstanding-plus-buffered requests (legal values 1..8).

Ports:
- clk_i  input  1  single clock; all state updates on rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- imem_req_v_o  output  1  request valid.
- imem_req_addr_o  output  32  request byte address, always word aligned.
- imem_req_ready_i  input  1  memory accepts request this cycle.
- imem_resp_v_i  input  1  response valid; responses return in request order and cannot be back-pressured.
- imem_resp_data_i  input  32  instruction word.
- redirect_v_i  input  1  redirect request from execute.
- redirect_pc_i  input  32  redirect target.
- fetch_v_o  output  1  buffer head valid.
- fetch_pc_o  output  32  PC of head word (rvga_word).
- fetch_ir_o  output  32  head instruction word (rvga_word).
- fetch_ready_i  input  1  decode consumes head this cycle.

Behaviour:
Reset (async assert, sync release):
- pc = RESET_PC; buffer empty; outstanding count = 0; state = e_FETCH_BOOT.
- All outputs 0: imem_req_v_o, fetch_v_o, fetch_pc_o, fetch_ir_o, imem_req_addr_o.

States:
- e_FETCH_BOOT: no request issued; unconditionally moves to e_FETCH_RUN next cycle.
- e_FETCH_RUN:
  - imem_req_v_o = 1 when (outstanding + buffered) < BUF_DEPTH; imem_req_addr_o = pc.
  - On req_v && req_ready: the request PC is pushed to an internal in-flight PC queue, pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0), and outstanding increments.
  - On resp_v: pop the in-flight PC and write {pc, data} to the buffer; outstanding decrements.
  - A resp into a full buffer is impossible by construction; assert in simulation.
- e_FETCH_FLUSH:
  - Entered on redirect when outstanding > 0 after this cycle's accounting.
  - imem_req_v_o = 0; every resp is dropped and decrements outstanding.
  - Moves to e_FETCH_RUN in the cycle after outstanding reaches 0.

Redirect (any state except e_FETCH_BOOT, where it is also honoured):
- pc <= {redirect_pc_i[31:2], 2'b00}; buffer cleared; fetch_v_o = 0 next cycle.
- A request handshaking in the same cycle still counts as outstanding and is later discarded.
- A response arriving in the same cycle is discarded.
- A redirect while in e_FETCH_FLUSH updates pc and stays in FLUSH.
- If outstanding == 0 after the redirect cycle, go directly to (or remain in) e_FETCH_RUN and issue to the new pc next cycle.

Output interface:
- fetch_v_o/pc/ir are driven combinationally from buffer head (registered storage); pop on fetch_v_o && fetch_ready_i.
- Push and pop in the same cycle on a full buffer is legal.
- Empty buffer: fetch_v_o = 0; ready ignored.
- Latency: request handshake at cycle N, response at N+k -> word visible on fetch_v_o at N+k+1.

Counter widths: $clog2(BUF_DEPTH+1).

Optional Feature:
- Macro RVGA_FETCH_PERF_EN.
- When defined, adds:
  - output perf_drop_cnt_o [31:0]: responses discarded due to redirect.
  - output perf_stall_cnt_o [31:0]: cycles with fetch_v_o=1 && fetch_ready_i=0.
  - Both counters reset to 0, saturate at 32'hFFFF_FFFF, and are unaffected by redirect.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- rvga_types package: rvga_fetch_state enum {e_FETCH_BOOT, e_FETCH_RUN, e_FETCH_FLUSH}; struct rvga_fetch_entry {rvga_word pc; rvga_word ir;}; localparam RVGA_INST_BYTES = 4.
- Sub-module rvga_fifo (parameterized width/depth, push/pop/clear, full/empty, simultaneous push+pop on full allowed).
- rvga_fifo is used twice: in-flight PC queue and response buffer.

Test Plan:
- Reset release, memory always ready, 1-cycle response, decode always ready -> first request addr 0x0 one cycle after BOOT; fetch_pc_o sequence 0x0, 0x4, 0x8 with ir matching memory, one word per cycle.
- fetch_ready_i held 0, BUF_DEPTH=2 -> exactly 2 requests issued, then imem_req_v_o=0; releasing ready resumes in order with no loss or duplication.
- Redirect to 0x103 with 2 requests outstanding -> FLUSH, both responses dropped, next request addr 0x100, first fetch_pc_o = 0x100.
- Redirect in the same cycle as a response and a request handshake -> response dropped, in-flight request later dropped, no stale word appears on fetch_v_o.
- RESET_PC=0xFFFF_FFF8 -> fetch_pc_o 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- RVGA_FETCH_PERF_EN: a scenario with 2 dropped responses and 5 stalled cycles -> perf_drop_cnt_o=2, perf_stall_cnt_o=5; rst_n_i asserted mid-run -> both counters 0 and all outputs 0 immediately.
